// File: rtl/ifu_fetch_bridge.sv
// ifu_fetch_bridge
//   Instruction-memory front end that sits directly upstream of the IFU
//   stage. It captures the IFU pc and issues one 64-bit read per
//   instruction on a valid/ready request port. It then selects the 32-bit
//   word for pc and presents it as a one-cycle instr/instr_valid pulse.
//   Responses made stale by an IFU redirect (jump_en) are discarded.
//   Misaligned pc, bus errors and response timeouts halt fetching and raise
//   a sticky fetch_err. Only reset clears fetch_err.
//
// Ports
//   clk, rstn        clock; synchronous active-low reset
//   pc, jump_en      IFU pc and redirect strobe (pc changes at the next edge)
//   instr            fetched instruction, held outside its valid pulse
//   instr_valid      one-cycle pulse, instr belongs to the current pc
//   mem_req_*        read request: valid/ready handshake, 8-byte-aligned addr
//   mem_resp_*       read response: data (little-endian) and error, no back-pressure
//   fetch_err        sticky error flag, fetching halted
//   fetch_err_pc     pc that caused the error
module ifu_fetch_bridge #(
  parameter int unsigned TIMEOUT  = 256,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] pc,
  input  logic        jump_en,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  input  logic        mem_resp_err,
  output logic        fetch_err,
  output logic [63:0] fetch_err_pc
);

  localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // RESET_PC only documents the IFU reset pc for the bench; nothing here uses it.
  logic unused_reset_pc;
  assign unused_reset_pc = ^RESET_PC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        req_pc_q, req_pc_d;
  logic               stale_q, stale_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               fetch_err_q, fetch_err_d;
  logic [63:0]        fetch_err_pc_q, fetch_err_pc_d;

  always_comb begin
    state_d        = state_q;
    req_pc_d       = req_pc_q;
    stale_d        = stale_q;
    cnt_d          = cnt_q;
    instr_d        = instr_q;
    instr_valid_d  = 1'b0;
    fetch_err_d    = fetch_err_q;
    fetch_err_pc_d = fetch_err_pc_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_LOAD;
      end

      S_LOAD: begin
        req_pc_d = pc;
        // A redirect seen here means the pc being captured is already dead.
        stale_d  = jump_en;
        if (pc[1:0] != 2'b00) begin
          // A misaligned pc that is being redirected away is not an error;
          // wait in LOAD for the jump target instead.
          if (!jump_en) begin
            state_d        = S_ERR;
            fetch_err_d    = 1'b1;
            fetch_err_pc_d = pc;
          end
        end else begin
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        // The request is never retracted once raised; a redirect only
        // marks the eventual response for discard.
        if (jump_en) stale_d = 1'b1;
        if (mem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (jump_en) stale_d = 1'b1;
        if (mem_resp_valid) begin
          if (stale_q || jump_en) begin
            // Discard both data and error of a stale response.
            state_d = S_LOAD;
            stale_d = 1'b0;
          end else if (mem_resp_err) begin
            state_d        = S_ERR;
            fetch_err_d    = 1'b1;
            fetch_err_pc_d = req_pc_q;
          end else begin
            instr_d       = req_pc_q[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];
            instr_valid_d = 1'b1;
            state_d       = S_VALID;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d        = S_ERR;
          fetch_err_d    = 1'b1;
          fetch_err_pc_d = req_pc_q;
        end
      end

      S_VALID: begin
        // A jump here needs no action: the IFU applies it and LOAD picks up
        // the new pc.
        state_d = S_LOAD;
        stale_d = 1'b0;
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      req_pc_q       <= '0;
      stale_q        <= 1'b0;
      cnt_q          <= '0;
      instr_q        <= '0;
      instr_valid_q  <= 1'b0;
      fetch_err_q    <= 1'b0;
      fetch_err_pc_q <= '0;
    end else begin
      state_q        <= state_d;
      req_pc_q       <= req_pc_d;
      stale_q        <= stale_d;
      cnt_q          <= cnt_d;
      instr_q        <= instr_d;
      instr_valid_q  <= instr_valid_d;
      fetch_err_q    <= fetch_err_d;
      fetch_err_pc_q <= fetch_err_pc_d;
    end
  end

  // The request address is derived from req_pc, which only changes in LOAD,
  // so it stays stable for the whole time REQ waits for ready.
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = (state_q == S_REQ) ? {req_pc_q[63:3], 3'b000} : 64'h0;
  assign instr         = instr_q;
  assign instr_valid   = instr_valid_q;
  assign fetch_err     = fetch_err_q;
  assign fetch_err_pc  = fetch_err_pc_q;

endmodule

// File: tb/tb_ifu_fetch_bridge.sv
module tb_ifu_fetch_bridge;

  localparam int unsigned TIMEOUT  = 8;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] pc;
  logic        jump_en;
  logic [31:0] instr;
  logic        instr_valid;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        mem_resp_err;
  logic        fetch_err;
  logic [63:0] fetch_err_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifu_fetch_bridge #(.TIMEOUT(TIMEOUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rstn(rstn), .pc(pc), .jump_en(jump_en),
    .instr(instr), .instr_valid(instr_valid),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .fetch_err(fetch_err), .fetch_err_pc(fetch_err_pc)
  );

  // Reference memory: a word-addressed instruction store, word at byte address a.
  function automatic logic [31:0] mem_w(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Bus line for the 8-byte block containing a, little-endian.
  function automatic logic [63:0] mem_line(input logic [63:0] a);
    logic [63:0] b;
    b = a & ~64'h7;
    return {mem_w(b + 64'd4), mem_w(b)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [63:0] p);
    rstn = 1'b0; pc = p; jump_en = 1'b0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_resp_data = {$urandom, $urandom};
    tick(); tick();
    rstn = 1'b1;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (mem_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (mem_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL req_wait: mem_req_valid=%b after %0d cycles, want 1", mem_req_valid, n);
    end
  endtask

  // One complete fetch of p: rw cycles of ready low, response lat cycles into WAIT.
  task automatic do_fetch(input logic [63:0] p, input int rw, input int lat,
                          input logic [63:0] line, input logic [31:0] exp, output int wcyc);
    logic [63:0] addr;
    addr = p & ~64'h7;
    pc = p;
    wait_req(wcyc);
    if (mem_req_valid !== 1'b1) return;
    total++;
    if (mem_req_addr !== addr) begin
      bad++; $display("FAIL req_addr: got %h want %h", mem_req_addr, addr);
    end
    for (int i = 0; i < rw; i++) begin
      mem_req_ready = 1'b0;
      tick();
      total++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== addr) begin
        bad++; $display("FAIL req_hold: valid=%b addr=%h want 1 %h", mem_req_valid, mem_req_addr, addr);
      end
    end
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    for (int i = 0; i < lat; i++) begin
      total++;
      if (instr_valid !== 1'b0) begin
        bad++; $display("FAIL early_valid: instr_valid=%b want 0", instr_valid);
      end
      tick();
    end
    mem_resp_valid = 1'b1; mem_resp_err = 1'b0; mem_resp_data = line;
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = {$urandom, $urandom};
    total++;
    if (instr_valid !== 1'b1 || instr !== exp) begin
      bad++; $display("FAIL fetch pc=%h: valid=%b instr=%h want 1 %h", p, instr_valid, instr, exp);
    end
    tick();
    total++;
    if (instr_valid !== 1'b0) begin
      bad++; $display("FAIL pulse_len pc=%h: instr_valid=%b want 0", p, instr_valid);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; pc = {$urandom, $urandom}; jump_en = 1'b1; mem_req_ready = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_err = 1'b1; mem_resp_data = {$urandom, $urandom};
    tick(); tick();
    total++;
    if (instr !== 32'h0 || instr_valid !== 1'b0 || mem_req_valid !== 1'b0 ||
        mem_req_addr !== 64'h0 || fetch_err !== 1'b0 || fetch_err_pc !== 64'h0) begin
      bad++;
      $display("FAIL reset_vals: instr=%h iv=%b rv=%b addr=%h fe=%b fepc=%h want all 0",
               instr, instr_valid, mem_req_valid, mem_req_addr, fetch_err, fetch_err_pc);
    end
  endtask

  task automatic test_basic();
    int w;
    do_reset(RESET_PC);
    do_fetch(64'h8000_0000, 0, 0, 64'h00000013_00100093, 32'h00100093, w);
    do_fetch(64'h8000_0004, 0, 0, 64'h00000013_00100093, 32'h00000013, w);
  endtask

  task automatic test_jump_wait();
    int n;
    do_reset(64'h8000_0008);
    wait_req(n);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    jump_en = 1'b1; tick(); jump_en = 1'b0; pc = 64'h8000_0100;
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = mem_line(64'h8000_0008); tick(); mem_resp_valid = 1'b0;
    total++;
    if (instr_valid !== 1'b0) begin
      bad++; $display("FAIL stale_discard: instr_valid=%b want 0", instr_valid);
    end
    do_fetch(64'h8000_0100, 0, 1, mem_line(64'h8000_0100), mem_w(64'h8000_0100), n);
    // An error response arriving together with a redirect is discarded too.
    pc = 64'h8000_0300;
    wait_req(n);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    jump_en = 1'b1; mem_resp_valid = 1'b1; mem_resp_err = 1'b1;
    tick();
    jump_en = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0; pc = 64'h8000_0400;
    total++;
    if (fetch_err !== 1'b0 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL stale_err_discard: fe=%b iv=%b want 0 0", fetch_err, instr_valid);
    end
    do_fetch(64'h8000_0400, 0, 0, mem_line(64'h8000_0400), mem_w(64'h8000_0400), n);
  endtask

  task automatic test_ready_stall();
    int n;
    do_reset(64'h8000_0020);
    wait_req(n);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0020) begin
        bad++; $display("FAIL stall_hold[%0d]: valid=%b addr=%h want 1 80000020", i, mem_req_valid, mem_req_addr);
      end
      mem_req_ready = 1'b0; jump_en = (i == 1);
      tick();
      jump_en = 1'b0;
      if (i == 1) pc = 64'h8000_0200;
    end
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = mem_line(64'h8000_0020); tick(); mem_resp_valid = 1'b0;
    total++;
    if (instr_valid !== 1'b0) begin
      bad++; $display("FAIL stall_discard: instr_valid=%b want 0", instr_valid);
    end
    do_fetch(64'h8000_0200, 2, 0, mem_line(64'h8000_0200), mem_w(64'h8000_0200), n);
  endtask

  task automatic test_bus_err();
    int n;
    do_reset(64'h8000_0010);
    wait_req(n);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_err = 1'b1; tick(); mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    total++;
    if (fetch_err !== 1'b1 || fetch_err_pc !== 64'h8000_0010 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL bus_err: fe=%b fepc=%h iv=%b want 1 80000010 0", fetch_err, fetch_err_pc, instr_valid);
    end
    mem_req_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_resp_valid = 1'($urandom_range(0, 1)); mem_resp_data = {$urandom, $urandom};
      pc = 64'h8000_0040;
      tick();
      total++;
      if (mem_req_valid !== 1'b0 || fetch_err !== 1'b1 || instr_valid !== 1'b0) begin
        bad++; $display("FAIL err_halt[%0d]: rv=%b fe=%b iv=%b want 0 1 0", i, mem_req_valid, fetch_err, instr_valid);
      end
    end
    do_reset(64'h8000_0002);
    total++;
    if (fetch_err !== 1'b0 || fetch_err_pc !== 64'h0) begin
      bad++; $display("FAIL err_cleared: fe=%b fepc=%h want 0 0", fetch_err, fetch_err_pc);
    end
    mem_req_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (mem_req_valid !== 1'b0) begin
        bad++; $display("FAIL misalign_noreq[%0d]: rv=%b want 0", i, mem_req_valid);
      end
    end
    mem_req_ready = 1'b0;
    total++;
    if (fetch_err !== 1'b1 || fetch_err_pc !== 64'h8000_0002) begin
      bad++; $display("FAIL misalign: fe=%b fepc=%h want 1 80000002", fetch_err, fetch_err_pc);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset(64'h8000_0040);
    wait_req(n);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    n = 0;
    while (fetch_err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n != int'(TIMEOUT) || fetch_err_pc !== 64'h8000_0040 || mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL timeout: rose after %0d cycles fepc=%h rv=%b want %0d 80000040 0",
                      n, fetch_err_pc, mem_req_valid, TIMEOUT);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    do_reset(64'h8000_0050);
    do_fetch(64'h8000_0050, 0, 0, mem_line(64'h8000_0050), mem_w(64'h8000_0050), n);
    pc = 64'h8000_0058;
    wait_req(n);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    tick(); tick(); tick();
    rstn = 1'b0; tick();
    total++;
    if (instr !== 32'h0 || instr_valid !== 1'b0 || mem_req_valid !== 1'b0 ||
        mem_req_addr !== 64'h0 || fetch_err !== 1'b0 || fetch_err_pc !== 64'h0) begin
      bad++; $display("FAIL mid_wait_reset: instr=%h iv=%b rv=%b addr=%h fe=%b fepc=%h want all 0",
                      instr, instr_valid, mem_req_valid, mem_req_addr, fetch_err, fetch_err_pc);
    end
    rstn = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = mem_line(64'h8000_0058);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (instr_valid !== 1'b0) begin
        bad++; $display("FAIL late_resp[%0d]: instr_valid=%b want 0", i, instr_valid);
      end
    end
    mem_resp_valid = 1'b0;
    do_fetch(64'h8000_0058, 0, 0, mem_line(64'h8000_0058), mem_w(64'h8000_0058), n);
  endtask

  task automatic test_back_to_back();
    int w;
    logic [63:0] p;
    do_reset(64'h8000_1000);
    for (int i = 0; i < 6; i++) begin
      p = 64'h8000_1000 + 64'(4 * i);
      do_fetch(p, 0, 0, mem_line(p), mem_w(p), w);
      if (i > 0) begin
        total++;
        if (w != 1) begin
          bad++; $display("FAIL b2b_gap[%0d]: req after %0d cycles want 1", i, w);
        end
      end
    end
  endtask

  task automatic test_random();
    int w;
    logic [63:0] p;
    do_reset(RESET_PC);
    for (int i = 0; i < 30; i++) begin
      p = RESET_PC + {52'h0, 10'($urandom_range(0, 1023)), 2'b00};
      do_fetch(p, $urandom_range(0, 3), $urandom_range(0, 5), mem_line(p), mem_w(p), w);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_jump_wait();
    test_ready_stall();
    test_bus_err();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
